alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 8-bit ALU between two requesters (0: execute unit, 1: address/fetch unit).
//  Round-robin arbitration with valid/ready request and response handshakes.
//  Sequences ALU: drives operands/control with a one-cycle execute pulse, captures the registered result and flags,
//  then returns them to the owning requester. Sits between the core control logic and the ALU.
// PARAMETERS
//  DATA_W      8   operand/result width; must equal ALU width
//  CTRL_W      3   ALU control width
//  FIXED_PRIO  0   0 = round-robin; 1 = requester 0 always wins when both valid
// PORTS
//  clk             in   1       clock, all state on posedge
//  rst_n           in   1       asynchronous active-low reset
//  reqN_valid      in   1       N=0,1: request present
//  reqN_ready      out  1       request accepted this cycle when valid&ready
//  reqN_a/reqN_b   in   DATA_W  operands
//  reqN_op         in   CTRL_W  ALU control code
//  rspN_valid      out  1       response held for requester N
//  rspN_ready      in   1       requester N takes response
//  rspN_data       out  DATA_W  result
//  rspN_zf/rspN_cf out  1       ALU flags at capture
//  alu_a/alu_b     out  DATA_W  to ALU in_a/in_b
//  alu_control     out  CTRL_W  to ALU control
//  alu_execute     out  1       to ALU execute
//  alu_out         in   DATA_W  ALU registered result
//  alu_zf/alu_cf   in   1       ALU registered flags
//  busy            out  1       high in any state but IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last_grant=1, so requester 0 wins first; operand/owner regs 0.
//  FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
//  IDLE: grant is combinational from valids. Single valid wins. Both valid: the one != last_grant wins
//   (FIXED_PRIO=1: req 0). reqG_ready=1 only for the winner, and only in IDLE; the other ready=0.
//   On accept, latch a, b, op and owner, then go to ISSUE.
//  ISSUE: alu_execute=1 for exactly this cycle; alu_a/b/control = latched values, held stable through CAPTURE.
//   Op 3'b101 is undefined: alu_execute stays 0 and a NOP flag is set.
//  CAPTURE: alu_out, alu_zf, alu_cf are valid (ALU registered at end of ISSUE). Latch into rsp regs.
//   NOP flag set: data=0, zf=cf=0.
//  RESP: rsp<owner>_valid=1; data and flags stable until rsp<owner>_ready.
//   On handshake: last_grant=owner, go IDLE. The other rspN_valid stays 0.
//  Flags: the ALU only updates zf/cf for op 3'b111; other ops return the ALU's current (stale) flags unchanged.
//  Latency: accept edge E; rsp_valid high in the cycle after edge E+2. Minimum 4 cycles per op, no pipelining.
//  Requests arriving while busy wait (ready=0); no request is dropped and the request inputs must stay held.
//  alu_execute is 0 outside ISSUE; alu_a/b/control hold the last values when idle.
//  rst_n low at any point: async return to IDLE, all outputs 0, in-flight op discarded, no response.
//   ALU internal registers are not reset by this block.
// TESTING
//  1. Reset, req0 op=110 a=8'h12 b=8'h34 -> ready0 1 cycle, alu_execute 1 pulse, rsp0_data=8'h46 after 3 edges.
//  2. req0 op=111 a=5 b=5 -> rsp0_data=0, zf=1, cf=0; then a=3 b=5 -> data=8'hFE, zf=0, cf=1.
//  3. Both valid every cycle, FIXED_PRIO=0 -> grants alternate 0,1,0,1; each gets correct result, none lost.
//  4. rsp1_ready held low 10 cycles -> rsp1 stable, busy=1, ready0/ready1=0, no alu_execute pulses.
//  5. op=101 -> no alu_execute, rsp data=0, zf=cf=0; next op=011 a=8'h80 b=3 -> data=8'h10.
//  6. rst_n pulsed low during CAPTURE -> immediate outputs 0, no rsp_valid, next request served normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered 8-bit ALU between two valid/ready requesters
module alu_arbiter #(
    parameter int DATA_W     = 8,
    parameter int CTRL_W     = 3,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_zf,
    output logic              rsp0_cf,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_zf,
    output logic              rsp1_cf,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic              alu_execute,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zf,
    input  logic              alu_cf,
    output logic              busy
);
    localparam logic [CTRL_W-1:0] OP_NOP = CTRL_W'(3'b101);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t            r_state;
    logic              r_last, r_owner, r_nop, r_exec, r_rv0, r_rv1, r_zf, r_cf;
    logic [DATA_W-1:0] r_a, r_b, r_data;
    logic [CTRL_W-1:0] r_op;
    logic              w_idle, w_gnt, w_acc, w_hs;
    logic [CTRL_W-1:0] w_op;
    // ready is gated by rst_n so every output reads 0 while reset is held
    assign w_idle = (r_state == IDLE) && rst_n;
    assign w_gnt  = (req0_valid && req1_valid) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last) : req1_valid;
    assign w_acc  = w_idle && (req0_valid || req1_valid);
    assign w_op   = w_gnt ? req1_op : req0_op;
    assign w_hs   = r_owner ? rsp1_ready : rsp0_ready;
    assign req0_ready  = w_idle && req0_valid && !w_gnt;
    assign req1_ready  = w_idle && req1_valid && w_gnt;
    assign rsp0_valid  = r_rv0;
    assign rsp1_valid  = r_rv1;
    assign rsp0_data   = r_data;
    assign rsp1_data   = r_data;
    assign rsp0_zf     = r_zf;
    assign rsp1_zf     = r_zf;
    assign rsp0_cf     = r_cf;
    assign rsp1_cf     = r_cf;
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_control = r_op;
    assign alu_execute = r_exec;
    assign busy        = r_state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_nop   <= 1'b0;
            r_exec  <= 1'b0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
            r_zf    <= 1'b0;
            r_cf    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_acc) begin
                    r_owner <= w_gnt;
                    r_a     <= w_gnt ? req1_a : req0_a;
                    r_b     <= w_gnt ? req1_b : req0_b;
                    r_op    <= w_op;
                    r_nop   <= w_op == OP_NOP;
                    r_exec  <= w_op != OP_NOP;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    r_exec  <= 1'b0;
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_data  <= r_nop ? '0 : alu_out;
                    r_zf    <= !r_nop && alu_zf;
                    r_cf    <= !r_nop && alu_cf;
                    r_rv0   <= !r_owner;
                    r_rv1   <= r_owner;
                    r_state <= RESP;
                end
                RESP: if (w_hs) begin
                    r_rv0   <= 1'b0;
                    r_rv1   <= 1'b0;
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
